// File: rtl/cam_pipe.sv
// Pipelined ternary CAM with per-entry valid bits. A search is compared against every
// entry in stage 1 and priority-encoded in stage 2, giving a fixed 2-cycle latency.
module cam_pipe #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] wr_care,
  input  logic              inv_en,
  input  logic [ADDR_W-1:0] inv_addr,
  input  logic              flush,
  input  logic              srch_valid,
  input  logic [DATA_W-1:0] srch_key,
  output logic              rslt_valid,
  output logic              rslt_match,
  output logic [ADDR_W-1:0] rslt_addr,
  output logic              rslt_multi,
  output logic [ADDR_W:0]   entry_count
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] data_reg [DEPTH];
  logic [DATA_W-1:0] care_reg [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  match_comb;
  logic [DEPTH-1:0]  match_vec_reg;
  logic [DEPTH-1:0]  match_vec_m1;
  logic              s1_valid_reg;
  logic              rslt_valid_reg;
  logic              rslt_match_reg;
  logic [ADDR_W-1:0] rslt_addr_reg;
  logic              rslt_multi_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W-1:0] enc_addr;
  logic              wr_ok;
  logic              inv_ok;
  logic              cnt_inc;
  logic              cnt_dec;

  // Addresses past the last entry only exist when DEPTH is not a power of two.
  assign wr_ok  = wr_en  && ({1'b0, wr_addr}  < DEPTH_L) && !flush;
  assign inv_ok = inv_en && ({1'b0, inv_addr} < DEPTH_L) && !flush;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      data_reg[wr_addr] <= wr_data;
      care_reg[wr_addr] <= wr_care;
    end
  end

  // Invalidate is applied after write so it wins on a shared address.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_reg <= '0;
    end else begin
      if (wr_ok)  valid_reg[wr_addr]  <= 1'b1;
      if (inv_ok) valid_reg[inv_addr] <= 1'b0;
    end
  end

  always_comb begin
    cnt_inc    = wr_ok && !valid_reg[wr_addr] && !(inv_ok && (inv_addr == wr_addr));
    cnt_dec    = inv_ok && valid_reg[inv_addr];
    count_next = count_reg + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) count_reg <= '0;
    else              count_reg <= count_next;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match_comb[gi] = valid_reg[gi] &&
                              (((data_reg[gi] ^ srch_key) & care_reg[gi]) == '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) s1_valid_reg <= 1'b0;
    else     s1_valid_reg <= srch_valid;
    match_vec_reg <= match_comb;
  end

  always_comb begin
    enc_addr = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_vec_reg[i]) enc_addr = ADDR_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign match_vec_m1 = match_vec_reg - {{(DEPTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      rslt_valid_reg <= 1'b0;
      rslt_match_reg <= 1'b0;
      rslt_addr_reg  <= '0;
      rslt_multi_reg <= 1'b0;
    end else begin
      rslt_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        rslt_match_reg <= |match_vec_reg;
        rslt_addr_reg  <= enc_addr;
        rslt_multi_reg <= |(match_vec_reg & match_vec_m1);
      end
    end
  end

  assign rslt_valid  = rslt_valid_reg;
  assign rslt_match  = rslt_match_reg;
  assign rslt_addr   = rslt_addr_reg;
  assign rslt_multi  = rslt_multi_reg;
  assign entry_count = count_reg;

endmodule

// File: doc/cam_pipe.md
Name: cam_pipe

Overview:
Parametrised, pipelined ternary content-addressable memory with per-entry valid bits.
- Stores DEPTH entries of DATA_W bits, each with a per-bit care mask.
- Each search returns the lowest matching address, a multi-hit flag and a live entry count.
- Sits between the lookup requester and the table-management logic. Writes, invalidates and flushes come from management; searches come from the datapath.

Parameters:
DATA_W, 8, key/entry width in bits (>=1)
DEPTH, 1024, number of entries (>=2, need not be a power of two)
ADDR_W, $clog2(DEPTH), entry address width (derived; not overridden)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_en  input  1  write entry at wr_addr and set its valid bit
wr_addr  input  ADDR_W  write target; values >= DEPTH ignored
wr_data  input  DATA_W  entry value
wr_care  input  DATA_W  per-bit compare enable (1 = compare, 0 = don't-care)
inv_en  input  1  clear valid bit of entry inv_addr
inv_addr  input  ADDR_W  invalidate target; values >= DEPTH ignored
flush  input  1  clear all valid bits
srch_valid  input  1  search request this cycle
srch_key  input  DATA_W  search key
rslt_valid  output  1  result qualifier, one pulse per accepted search
rslt_match  output  1  at least one valid entry matched
rslt_addr  output  ADDR_W  lowest matching address, 0 when no match
rslt_multi  output  1  two or more valid entries matched
entry_count  output  ADDR_W+1  number of valid entries

Behaviour:
- Reset: all valid bits = 0. rslt_valid, rslt_match, rslt_multi = 0. rslt_addr = 0. entry_count = 0. In-flight searches are dropped. Entry data/care contents are not reset.
- Match rule for entry i: valid[i] and ((data[i] ^ srch_key) & care[i]) == 0. All-zero care matches any key.
- Pipeline, fixed 2-cycle latency, no back-pressure, one search accepted every cycle:
  - Stage 1 (edge N): register the match vector of all DEPTH entries for the search presented in cycle N.
  - Stage 2 (edge N+1): priority-encode the registered vector into rslt_*; rslt_valid = 1 in cycle N+2.
- rslt_valid = 0 whenever the corresponding cycle had srch_valid = 0. rslt_match, rslt_addr and rslt_multi are then don't-care but hold their last values.
- Table update ordering:
  - A write, invalidate or flush applied at edge N is visible to searches presented in cycle N+1 onward.
  - A search presented in the same cycle as an update sees the pre-update table.
- Same-cycle priority, highest first:
  1. flush: all valid = 0, entry_count = 0, wr_en/inv_en ignored.
  2. inv_en and wr_en to the same address: invalidate wins; data is still written but the entry is invalid.
  3. inv_en and wr_en to different addresses: both apply.
- entry_count:
  - Write to an invalid entry: +1.
  - Write to a valid entry (overwrite): no change.
  - Invalidate of a valid entry: -1.
  - Invalidate of an invalid entry: no change.
  - Write and invalidate in the same cycle: sum of both effects.
  - Range is 0..DEPTH inclusive; it never wraps.
- Out-of-range wr_addr/inv_addr (>= DEPTH, possible when DEPTH is not a power of two): the operation is ignored with no count change.
- rslt_multi is set when popcount(match vector) >= 2. It is independent of which address is reported.
- srch_valid during rst is ignored. The first search is accepted in the cycle after rst deasserts.

Test Plan:
- Reset, then search key 0x5A -> 2 cycles later rslt_valid=1, rslt_match=0, rslt_addr=0, rslt_multi=0, entry_count=0.
- Write addr 7 = 0x5A with care 0xFF, then addr 3 = 0x5A with care 0xFF; search 0x5A -> rslt_match=1, rslt_addr=3, rslt_multi=1, entry_count=2. Invalidate addr 3, search 0x5A -> rslt_addr=7, rslt_multi=0, entry_count=1.
- Ternary: write addr 10 = 0xA0 with care 0xF0; search 0xA7 -> match at 10; search 0xB7 -> rslt_match=0.
- Hazard: in one cycle write addr 5 = 0x11 and search 0x11 -> no match; search 0x11 the next cycle -> match at 5. Back-to-back searches 0x11, 0x22, 0x11 on consecutive cycles -> three consecutive rslt_valid pulses with results match/5, no-match, match/5.
- Simultaneous events: with 4 valid entries, apply wr_en to invalid addr 20 plus inv_en to valid addr 1 -> entry_count unchanged at 4. Apply wr_en and inv_en both to addr 30 -> entry 30 invalid. Apply flush with wr_en -> entry_count=0 and all searches miss.
- Boundaries: fill all DEPTH entries -> entry_count=DEPTH; overwrite addr DEPTH-1 -> count unchanged. Assert rst while a search is in flight -> no rslt_valid pulse after reset, count=0.
